// File: rtl/data_matrix_memory_interface_if.sv
// Request/ready handshake between the LC-3 MAR/MDR stage (master) and external memory (slave).
interface data_matrix_memory_interface_if;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ready;

  modport master (output mem_req, mem_we, mem_addr, mem_wdata, input mem_rdata, mem_ready);
  modport slave  (input mem_req, mem_we, mem_addr, mem_wdata, output mem_rdata, mem_ready);
endinterface

// File: rtl/data_matrix_memory_interface.sv
// LC-3 MAR/MDR memory-access stage: IDLE/REQ/DONE handshake with timeout abort.
// Define DATA_MATRIX_MMIO_EN to serve KBSR/KBDR/DSR/DDR (xFE00..xFE06) locally.
module data_matrix_memory_interface #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] bus_in,
  input  logic        ld_mar,
  input  logic        ld_mdr,
  input  logic        mio_en,
  input  logic        r_w,
  input  logic        gate_mdr,
  output logic [15:0] mdr_bus,
  output logic        r,
  output logic        mem_err,
  input  logic [7:0]  kbd_data,
  input  logic        kbd_valid,
  output logic [7:0]  disp_data,
  output logic        disp_valid,
  data_matrix_memory_interface_if.master mem
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_DONE = 2'd2} state_e;

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYC - 1);

  state_e      state_q, state_d;
  logic [15:0] mar_q, mar_d;
  logic [15:0] mdr_q, mdr_d;
  logic [15:0] cnt_q, cnt_d;
  logic        err_q, err_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic        r_q, r_d;

`ifdef DATA_MATRIX_MMIO_EN
  logic        kbsr_rdy_q, kbsr_rdy_d;
  logic [7:0]  kbdr_q, kbdr_d;
  logic [7:0]  disp_data_q, disp_data_d;
  logic        disp_valid_q, disp_valid_d;
  logic [15:0] addr_s;
  logic        mmio_hit_s;

  // The access address is the one MAR will hold, so a same-cycle ld_mar is honoured.
  assign addr_s     = ld_mar ? bus_in : mar_q;
  assign mmio_hit_s = (addr_s[15:3] == 13'h1FC0) && !addr_s[0];
`else
  logic unused_kbd_s;
  assign unused_kbd_s = ^{kbd_data, kbd_valid};
`endif

  // Next-state, datapath register and handshake output decode.
  always_comb begin
    state_d = state_q;
    mar_d   = mar_q;
    mdr_d   = mdr_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    we_d    = we_q;
`ifdef DATA_MATRIX_MMIO_EN
    kbsr_rdy_d   = kbsr_rdy_q;
    kbdr_d       = kbdr_q;
    disp_data_d  = disp_data_q;
    disp_valid_d = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (ld_mar) mar_d = bus_in;
        else        mar_d = mar_q;
        if (mio_en) begin
          we_d    = r_w;
          cnt_d   = 16'd0;
          err_d   = 1'b0;
          state_d = S_REQ;
`ifdef DATA_MATRIX_MMIO_EN
          if (mmio_hit_s) begin
            state_d = S_DONE;
            case (addr_s[2:1])
              2'd0: if (!r_w) mdr_d = {kbsr_rdy_q, 15'd0}; else mdr_d = mdr_q;
              2'd1: begin
                if (!r_w) begin
                  mdr_d      = {8'h00, kbdr_q};
                  kbsr_rdy_d = 1'b0;
                end else begin
                  mdr_d = mdr_q;
                end
              end
              2'd2: if (!r_w) mdr_d = 16'h8000; else mdr_d = mdr_q;
              2'd3: begin
                if (r_w) begin
                  disp_data_d  = mdr_q[7:0];
                  disp_valid_d = 1'b1;
                end else begin
                  mdr_d = 16'h0000;
                end
              end
              default: mdr_d = mdr_q;
            endcase
          end else begin
            state_d = S_REQ;
          end
`endif
        end else if (ld_mdr) begin
          mdr_d = bus_in;
        end else begin
          mdr_d = mdr_q;
        end
      end
      S_REQ: begin
        if (mem.mem_ready) begin
          state_d = S_DONE;
          if (!we_q) mdr_d = mem.mem_rdata;
          else       mdr_d = mdr_q;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
`ifdef DATA_MATRIX_MMIO_EN
    // A keyboard strobe wins over a same-cycle KBDR read clearing the ready bit.
    if (kbd_valid) begin
      kbsr_rdy_d = 1'b1;
      kbdr_d     = kbd_data;
    end else begin
      kbdr_d = kbdr_d;
    end
`endif
    req_d = (state_d == S_REQ);
    r_d   = (state_q == S_DONE);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      mar_q   <= 16'h0000;
      mdr_q   <= 16'h0000;
      cnt_q   <= 16'h0000;
      err_q   <= 1'b0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      r_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      mar_q   <= mar_d;
      mdr_q   <= mdr_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      req_q   <= req_d;
      we_q    <= we_d;
      r_q     <= r_d;
    end
  end

`ifdef DATA_MATRIX_MMIO_EN
  // Memory-mapped keyboard and display registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kbsr_rdy_q   <= 1'b0;
      kbdr_q       <= 8'h00;
      disp_data_q  <= 8'h00;
      disp_valid_q <= 1'b0;
    end else begin
      kbsr_rdy_q   <= kbsr_rdy_d;
      kbdr_q       <= kbdr_d;
      disp_data_q  <= disp_data_d;
      disp_valid_q <= disp_valid_d;
    end
  end

  assign disp_data  = disp_data_q;
  assign disp_valid = disp_valid_q;
`else
  assign disp_data  = 8'h00;
  assign disp_valid = 1'b0;
`endif

  assign mdr_bus       = gate_mdr ? mdr_q : 16'hzzzz;
  assign r             = r_q;
  assign mem_err       = err_q;
  assign mem.mem_req   = req_q;
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = mar_q;
  assign mem.mem_wdata = mdr_q;

endmodule

// File: tb/tb_data_matrix_memory_interface.sv
// Self-checking bench for data_matrix_memory_interface (TIMEOUT_CYC=4): vector table,
// randomized accesses against a transaction-level model, and reset/back-to-back corners.
module tb_data_matrix_memory_interface;
  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] bus_in = 16'h0000;
  logic        ld_mar = 1'b0, ld_mdr = 1'b0, mio_en = 1'b0, r_w = 1'b0, gate_mdr = 1'b0;
  wire  [15:0] mdr_bus;
  logic        r, mem_err, disp_valid;
  logic [7:0]  kbd_data = 8'h00;
  logic        kbd_valid = 1'b0;
  logic [7:0]  disp_data;

  data_matrix_memory_interface_if mem_if();

  data_matrix_memory_interface #(.TIMEOUT_CYC(T)) dut (
    .clk(clk), .rst_n(rst_n), .bus_in(bus_in), .ld_mar(ld_mar), .ld_mdr(ld_mdr),
    .mio_en(mio_en), .r_w(r_w), .gate_mdr(gate_mdr), .mdr_bus(mdr_bus), .r(r),
    .mem_err(mem_err), .kbd_data(kbd_data), .kbd_valid(kbd_valid),
    .disp_data(disp_data), .disp_valid(disp_valid), .mem(mem_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        rw;
    int          lat;
    logic [15:0] rdata;
    int          exp_req;
    logic        exp_err;
    logic [15:0] exp_mdr;
  } vec_t;

  vec_t vecs[6];
  int checks = 0;
  int failures = 0;
  logic [15:0] mdr_m;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic read_mdr(output logic [15:0] v);
    gate_mdr = 1'b1;
    #1;
    v = mdr_bus;
    gate_mdr = 1'b0;
  endtask

  // Drives one complete access and reports what the memory side observed.
  task automatic run_access(input logic [15:0] addr, input logic [15:0] wd, input logic rw,
                            input int lat, input logic [15:0] rdata,
                            output int req_cyc, output int r_edges,
                            output logic [15:0] seen_addr, output logic seen_we,
                            output logic [15:0] seen_wdata);
    int edges;
    bus_in = addr; ld_mar = 1'b1;
    step();
    ld_mar = 1'b0;
    if (rw) begin
      bus_in = wd; ld_mdr = 1'b1;
      step();
      ld_mdr = 1'b0;
    end
    mio_en = 1'b1; r_w = rw;
    step();
    mio_en = 1'b0; r_w = 1'b0;
    edges = 1; req_cyc = 0;
    seen_addr = 16'h0000; seen_we = 1'b0; seen_wdata = 16'h0000;
    while (mem_if.mem_req && req_cyc < 20) begin
      seen_addr  = mem_if.mem_addr;
      seen_we    = mem_if.mem_we;
      seen_wdata = mem_if.mem_wdata;
      mem_if.mem_ready = (req_cyc == lat);
      mem_if.mem_rdata = (req_cyc == lat) ? rdata : ~rdata;
      step();
      mem_if.mem_ready = 1'b0;
      edges++; req_cyc++;
    end
    r_edges = -1;
    for (int k = 0; k < 6; k++) begin
      if (r) begin
        r_edges = edges;
        break;
      end
      step();
      edges++;
    end
  endtask

  // Checks one finished access against the expected outcome.
  task automatic check_access(input string tag, input logic [15:0] addr, input logic [15:0] wd,
                              input logic rw, input int exp_req, input logic exp_err,
                              input logic [15:0] exp_mdr, input int req_cyc, input int r_edges,
                              input logic [15:0] sa, input logic swe, input logic [15:0] swd);
    logic [15:0] v;
    chk({tag, " req_cycles"}, req_cyc, exp_req);
    chk({tag, " r_latency"}, r_edges, exp_req + 2);
    if (exp_req > 0) begin
      chk({tag, " mem_addr"}, sa, addr);
      chk({tag, " mem_we"}, swe, rw);
      chk({tag, " mem_wdata"}, swd, rw ? wd : mdr_m);
    end
    step();
    chk({tag, " r_pulse_end"}, r, 1'b0);
    chk({tag, " mem_err"}, mem_err, exp_err);
    read_mdr(v);
    chk({tag, " mdr"}, v, exp_mdr);
    mdr_m = exp_mdr;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int rq, re, nreq, nr;
    logic [15:0] sa, swd, v, a, d, rd;
    logic swe, rw;
    int lat, ereq;
    logic eerr;
    logic [15:0] emdr;

    vecs[0] = '{16'h3000, 16'h0000, 1'b0, 2,  16'hABCD, 3, 1'b0, 16'hABCD};
    vecs[1] = '{16'h4000, 16'h1234, 1'b1, 0,  16'h0000, 1, 1'b0, 16'h1234};
    vecs[2] = '{16'h5000, 16'h0000, 1'b0, 9,  16'h5A5A, 4, 1'b1, 16'h1234};
    vecs[3] = '{16'h6000, 16'h0000, 1'b0, 3,  16'h0F0F, 4, 1'b0, 16'h0F0F};
    vecs[4] = '{16'h7000, 16'hBEEF, 1'b1, 4,  16'h1111, 4, 1'b1, 16'hBEEF};
    vecs[5] = '{16'h0001, 16'h0000, 1'b0, 1,  16'h0042, 2, 1'b0, 16'h0042};

    mem_if.mem_ready = 1'b0;
    mem_if.mem_rdata = 16'h0000;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    step();

    chk("rst mem_req", mem_if.mem_req, 1'b0);
    chk("rst mem_we", mem_if.mem_we, 1'b0);
    chk("rst mem_addr", mem_if.mem_addr, 16'h0000);
    chk("rst mem_wdata", mem_if.mem_wdata, 16'h0000);
    chk("rst r", r, 1'b0);
    chk("rst mem_err", mem_err, 1'b0);
    chk("rst disp_valid", disp_valid, 1'b0);
    chk("rst disp_data", disp_data, 8'h00);
    read_mdr(v);
    chk("rst mdr", v, 16'h0000);
    mdr_m = 16'h0000;

    for (int i = 0; i < 6; i++) begin
      run_access(vecs[i].addr, vecs[i].wdata, vecs[i].rw, vecs[i].lat, vecs[i].rdata,
                 rq, re, sa, swe, swd);
      check_access($sformatf("vec%0d", i), vecs[i].addr, vecs[i].wdata, vecs[i].rw,
                   vecs[i].exp_req, vecs[i].exp_err, vecs[i].exp_mdr, rq, re, sa, swe, swd);
    end

    // mem_ready while idle must not touch MDR or raise a request.
    mem_if.mem_ready = 1'b1; mem_if.mem_rdata = 16'hDEAD;
    step(); step();
    mem_if.mem_ready = 1'b0;
    chk("idle_ready mem_req", mem_if.mem_req, 1'b0);
    read_mdr(v);
    chk("idle_ready mdr", v, mdr_m);

    for (int i = 0; i < 30; i++) begin
      a   = 16'($urandom) & 16'h7FFF;
      d   = 16'($urandom);
      rd  = 16'($urandom);
      rw  = 1'($urandom_range(0, 1));
      lat = $urandom_range(0, 5);
      ereq = (lat < T) ? lat + 1 : T;
      eerr = (lat >= T);
      emdr = rw ? d : (eerr ? mdr_m : rd);
      run_access(a, d, rw, lat, rd, rq, re, sa, swe, swd);
      check_access($sformatf("rnd%0d", i), a, d, rw, ereq, eerr, emdr, rq, re, sa, swe, swd);
    end

    // ld_mar/ld_mdr are ignored mid-access; async reset aborts the access.
    bus_in = 16'h8000; ld_mar = 1'b1;
    step();
    ld_mar = 1'b0; mio_en = 1'b1;
    step();
    mio_en = 1'b0; bus_in = 16'h5555; ld_mar = 1'b1; ld_mdr = 1'b1;
    step();
    ld_mar = 1'b0; ld_mdr = 1'b0;
    chk("req_ld mem_req", mem_if.mem_req, 1'b1);
    chk("req_ld mem_addr", mem_if.mem_addr, 16'h8000);
    chk("req_ld mem_wdata", mem_if.mem_wdata, mdr_m);
    #2 rst_n = 1'b0;
    #1;
    chk("arst mem_req", mem_if.mem_req, 1'b0);
    chk("arst mem_addr", mem_if.mem_addr, 16'h0000);
    chk("arst mem_wdata", mem_if.mem_wdata, 16'h0000);
    chk("arst mem_err", mem_err, 1'b0);
    step();
    rst_n = 1'b1;
    mdr_m = 16'h0000;
    step();
    chk("post_rst mem_req", mem_if.mem_req, 1'b0);

    // Back-to-back reads with mio_en and mem_ready held high.
    mem_if.mem_ready = 1'b1; mem_if.mem_rdata = 16'h0C0C;
    mio_en = 1'b1;
    step();
    nreq = 0; nr = 0;
    for (int k = 0; k < 6; k++) begin
      if (mem_if.mem_req) nreq++;
      if (r) nr++;
      if (k == 5) mio_en = 1'b0;
      if (k < 5) step();
    end
    mem_if.mem_ready = 1'b0;
    chk("b2b req_cycles", nreq, 2);
    chk("b2b r_pulses", nr, 2);
    step(); step();
    read_mdr(v);
    chk("b2b mdr", v, 16'h0C0C);
    mdr_m = 16'h0C0C;

`ifdef DATA_MATRIX_MMIO_EN
    kbd_data = 8'h41; kbd_valid = 1'b1;
    step();
    kbd_valid = 1'b0;
    run_access(16'hFE00, 16'h0000, 1'b0, 0, 16'h0000, rq, re, sa, swe, swd);
    check_access("kbsr1", 16'hFE00, 16'h0000, 1'b0, 0, 1'b0, 16'h8000, rq, re, sa, swe, swd);
    run_access(16'hFE02, 16'h0000, 1'b0, 0, 16'h0000, rq, re, sa, swe, swd);
    check_access("kbdr", 16'hFE02, 16'h0000, 1'b0, 0, 1'b0, 16'h0041, rq, re, sa, swe, swd);
    run_access(16'hFE00, 16'h0000, 1'b0, 0, 16'h0000, rq, re, sa, swe, swd);
    check_access("kbsr2", 16'hFE00, 16'h0000, 1'b0, 0, 1'b0, 16'h0000, rq, re, sa, swe, swd);
    bus_in = 16'hFE06; ld_mar = 1'b1;
    step();
    ld_mar = 1'b0; bus_in = 16'h0058; ld_mdr = 1'b1;
    step();
    ld_mdr = 1'b0; mio_en = 1'b1; r_w = 1'b1;
    step();
    mio_en = 1'b0; r_w = 1'b0;
    chk("ddr disp_valid", disp_valid, 1'b1);
    chk("ddr disp_data", disp_data, 8'h58);
    chk("ddr mem_req", mem_if.mem_req, 1'b0);
    step();
    chk("ddr disp_valid_end", disp_valid, 1'b0);
    chk("ddr r", r, 1'b1);
    step();
`else
    chk("nommio disp_valid", disp_valid, 1'b0);
    chk("nommio disp_data", disp_data, 8'h00);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
